// File: rtl/ddr3_arb_pkg.sv
// Shared types and helpers for the DDR3 AXI port arbiter.
// Holds the FSM state enum, requester id constants and the round-robin
// pick function used by rr_arbiter4.
package ddr3_arb_pkg;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned AXI_ID_W = 4;

    // Requester ids; bit 1 set means a reader, bit 0 is the port index.
    localparam logic [1:0] ID_W0 = 2'd0;
    localparam logic [1:0] ID_W1 = 2'd1;
    localparam logic [1:0] ID_R0 = 2'd2;
    localparam logic [1:0] ID_R1 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_AR,
        ST_R
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] id;
    } pick_t;

    // First asserted request searching upward from ptr+1, wrapping mod 4.
    function automatic pick_t rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        pick_t      p;
        logic [1:0] idx;
        p.valid = 1'b0;
        p.id    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!p.valid && req[idx]) begin
                p.valid = 1'b1;
                p.id    = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/ddr3_axi_arbiter_rr.sv
// rr_arbiter4: four-way round-robin pick with a registered last-winner pointer.
// Ports:
//   clk, rst       clock, synchronous active-high reset (pointer -> 3)
//   req[3:0]       request vector indexed by requester id
//   take           arbitration slot open; pointer moves only when a pick is taken
//   pick_valid_c   combinational: some request is pending
//   pick_id_c      combinational: id of the winner
module rr_arbiter4
    import ddr3_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       take,
    output logic       pick_valid_c,
    output logic [1:0] pick_id_c
);

    logic [1:0] ptr;
    pick_t      pick;

    assign pick         = rr_pick(req, ptr);
    assign pick_valid_c = pick.valid;
    assign pick_id_c    = pick.id;

    // Pointer remembers the last winner so it has lowest priority next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= ID_R1;
        end else if (take && pick.valid) begin
            ptr <= pick.id;
        end
    end

endmodule

// File: rtl/ddr3_axi_arbiter.sv
// ddr3_axi_arbiter: shares the DDR3 wrapper AXI port between two burst
// writers and two burst readers, one transaction in flight at a time.
// Ports (port-group vectors are flattened, port n at [n*W +: W]):
//   clk, rst, inited                      clock, sync reset, controller ready
//   wr_req/addr/len/ack/data/strb/next/done   writer 0/1 request and data
//   rd_req/addr/len/ack, rd_data/valid/last   reader 0/1 request and data
//   axi_aw*/w*, axi_ar*/r*                to/from the DDR3 wrapper
//   busy                                  FSM not idle
//   len_err                               sticky read burst length mismatch
module ddr3_axi_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 256,
    parameter int unsigned LEN_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inited,
    input  logic [1:0]              wr_req,
    input  logic [2*ADDR_W-1:0]     wr_addr,
    input  logic [2*LEN_W-1:0]      wr_len,
    output logic [1:0]              wr_ack,
    input  logic [2*DATA_W-1:0]     wr_data,
    input  logic [2*(DATA_W/8)-1:0] wr_strb,
    output logic [1:0]              wr_next,
    output logic [1:0]              wr_done,
    input  logic [1:0]              rd_req,
    input  logic [2*ADDR_W-1:0]     rd_addr,
    input  logic [2*LEN_W-1:0]      rd_len,
    output logic [1:0]              rd_ack,
    output logic [DATA_W-1:0]       rd_data,
    output logic [1:0]              rd_valid,
    output logic [1:0]              rd_last,
    output logic [ADDR_W-1:0]       axi_awaddr,
    output logic [LEN_W-1:0]        axi_awlen,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [DATA_W-1:0]       axi_wdata,
    output logic [DATA_W/8-1:0]     axi_wstrb,
    input  logic                    axi_wready,
    input  logic                    axi_wusero_last,
    output logic [ADDR_W-1:0]       axi_araddr,
    output logic [LEN_W-1:0]        axi_arlen,
    output logic                    axi_arvalid,
    input  logic                    axi_arready,
    input  logic [DATA_W-1:0]       axi_rdata,
    input  logic [AXI_ID_W-1:0]     axi_rid,
    input  logic                    axi_rlast,
    input  logic                    axi_rvalid,
    output logic                    busy,
    output logic                    len_err
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_t             state, state_nxt;
    logic [1:0]         gnt_id;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt;
    logic               cnt_clr, cnt_inc, err_set;

    logic [3:0]         req_vec;
    logic               arb_take, grant;
    logic               pick_valid;
    logic [1:0]         pick_id;
    logic [ADDR_W-1:0]  pick_addr;
    logic [LEN_W-1:0]   pick_len;
    logic               port;

    // wusero_last and rid carry no control meaning here; gnt_id[1] is implied by state.
    logic               unused_inputs;
    assign unused_inputs = ^{axi_wusero_last, axi_rid, gnt_id[1]};

    assign req_vec  = {rd_req[1], rd_req[0], wr_req[1], wr_req[0]};
    assign arb_take = inited && (state == ST_IDLE);
    assign grant    = arb_take && pick_valid;
    assign port     = gnt_id[0];

    rr_arbiter4 u_arb (
        .clk          (clk),
        .rst          (rst),
        .req          (req_vec),
        .take         (arb_take),
        .pick_valid_c (pick_valid),
        .pick_id_c    (pick_id)
    );

    // Address/len of the winning requester, captured at grant.
    always_comb begin
        pick_addr = wr_addr[0 +: ADDR_W];
        pick_len  = wr_len[0 +: LEN_W];
        case (pick_id)
            ID_W1: begin
                pick_addr = wr_addr[ADDR_W +: ADDR_W];
                pick_len  = wr_len[LEN_W +: LEN_W];
            end
            ID_R0: begin
                pick_addr = rd_addr[0 +: ADDR_W];
                pick_len  = rd_len[0 +: LEN_W];
            end
            ID_R1: begin
                pick_addr = rd_addr[ADDR_W +: ADDR_W];
                pick_len  = rd_len[LEN_W +: LEN_W];
            end
            default: ;
        endcase
    end

    // State, grant capture, beat counter and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            gnt_id  <= 2'd0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt     <= '0;
            len_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                gnt_id <= pick_id;
                addr_q <= pick_addr;
                len_q  <= pick_len;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + LEN_W'(1);
            end
            if (err_set) begin
                len_err <= 1'b1;
            end
        end
    end

    // Next state and handshake decode.
    always_comb begin
        state_nxt   = state;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        err_set     = 1'b0;
        wr_ack      = 2'b00;
        wr_next     = 2'b00;
        wr_done     = 2'b00;
        rd_ack      = 2'b00;
        rd_valid    = 2'b00;
        rd_last     = 2'b00;
        axi_awvalid = 1'b0;
        axi_arvalid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    state_nxt = pick_id[1] ? ST_AR : ST_AW;
                end
            end
            ST_AW: begin
                axi_awvalid = 1'b1;
                if (axi_awready) begin
                    wr_ack[port] = 1'b1;
                    cnt_clr      = 1'b1;
                    state_nxt    = ST_W;
                end
            end
            ST_W: begin
                if (axi_wready) begin
                    wr_next[port] = 1'b1;
                    if (cnt == len_q) begin
                        wr_done[port] = 1'b1;
                        state_nxt     = ST_IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_AR: begin
                axi_arvalid = 1'b1;
                if (axi_arready) begin
                    rd_ack[port] = 1'b1;
                    cnt_clr      = 1'b1;
                    state_nxt    = ST_R;
                end
            end
            ST_R: begin
                if (axi_rvalid) begin
                    rd_valid[port] = 1'b1;
                    if (axi_rlast) begin
                        rd_last[port] = 1'b1;
                        err_set       = (cnt != len_q);
                        state_nxt     = ST_IDLE;
                    end else if (cnt == len_q) begin
                        // len+1 beats seen without rlast; keep waiting for it.
                        err_set = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy       = (state != ST_IDLE);
    assign axi_awaddr = addr_q;
    assign axi_awlen  = len_q;
    assign axi_araddr = addr_q;
    assign axi_arlen  = len_q;
    assign axi_wdata  = port ? wr_data[DATA_W +: DATA_W] : wr_data[0 +: DATA_W];
    assign axi_wstrb  = port ? wr_strb[STRB_W +: STRB_W] : wr_strb[0 +: STRB_W];
    assign rd_data    = axi_rdata;

endmodule

// File: tb/tb_ddr3_axi_arbiter.sv
// Directed bench for ddr3_axi_arbiter: a table of single transactions plus
// hand-written sequences for reset, init gating, round-robin order, read
// stall, early rlast and reset in the middle of a write burst.
module tb_ddr3_axi_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         inited;
    logic [1:0]   wr_req, rd_req;
    logic [55:0]  wr_addr, rd_addr;
    logic [7:0]   wr_len, rd_len;
    logic [1:0]   wr_ack, wr_next, wr_done, rd_ack, rd_valid, rd_last;
    logic [511:0] wr_data;
    logic [63:0]  wr_strb;
    logic [255:0] rd_data;
    logic [27:0]  axi_awaddr, axi_araddr;
    logic [3:0]   axi_awlen, axi_arlen;
    logic         axi_awvalid, axi_awready, axi_wready, axi_wusero_last;
    logic         axi_arvalid, axi_arready, axi_rlast, axi_rvalid;
    logic [255:0] axi_wdata, axi_rdata;
    logic [31:0]  axi_wstrb;
    logic [3:0]   axi_rid;
    logic         busy, len_err;

    int vec_count  = 0;
    int miss_count = 0;

    always #5 clk = ~clk;

    ddr3_axi_arbiter dut (
        .clk(clk), .rst(rst), .inited(inited),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_next(wr_next), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wready(axi_wready), .axi_wusero_last(axi_wusero_last),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rid(axi_rid),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
        .busy(busy), .len_err(len_err)
    );

    // One transaction: request and the outputs it must produce.
    typedef struct {
        int          id;
        logic [27:0] addr;
        int          len;
        int          stall;       // cycles with ready low in the address phase
        int          rlast_beat;  // beat index carrying rlast (reads)
        logic        awv;
        logic        arv;
        logic [1:0]  wack;        // expected wr_ack / wr_next mask
        logic [1:0]  rack;        // expected rd_ack / rd_valid mask
        int          beats;
        logic        err;         // expected len_err after the burst
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] wpat(input int p, input int b);
        logic [31:0] w;
        w = 32'(((p + 1) << 28) | b);
        return {8{w}};
    endfunction

    function automatic logic [255:0] rpat(input int b);
        logic [31:0] w;
        w = 32'h0A5A_0000 | 32'(b);
        return {8{w}};
    endfunction

    task automatic set_req(input vec_t v);
        case (v.id)
            0: begin wr_addr[27:0]  = v.addr; wr_len[3:0] = 4'(v.len); wr_req[0] = 1'b1; end
            1: begin wr_addr[55:28] = v.addr; wr_len[7:4] = 4'(v.len); wr_req[1] = 1'b1; end
            2: begin rd_addr[27:0]  = v.addr; rd_len[3:0] = 4'(v.len); rd_req[0] = 1'b1; end
            default: begin rd_addr[55:28] = v.addr; rd_len[7:4] = 4'(v.len); rd_req[1] = 1'b1; end
        endcase
    endtask

    // Called at the negedge of an IDLE cycle with the request visible; returns
    // at the negedge of the IDLE cycle after the burst.
    task automatic serve(input vec_t v, input logic [3:0] drop);
        @(negedge clk);
        axi_awready = v.awv && (v.stall == 0);
        axi_arready = v.arv && (v.stall == 0);
        #1;
        chk("awvalid", axi_awvalid, v.awv);
        chk("arvalid", axi_arvalid, v.arv);
        chk("addr", v.awv ? axi_awaddr : axi_araddr, v.addr);
        chk("len", v.awv ? axi_awlen : axi_arlen, v.len);
        for (int s = 0; s < v.stall; s++) begin
            chk("early_ack", {wr_ack, rd_ack}, 4'b0000);
            @(negedge clk);
            if (s == v.stall - 1) begin
                axi_awready = v.awv;
                axi_arready = v.arv;
            end
            #1;
            chk("stall_valid", v.awv ? axi_awvalid : axi_arvalid, 1'b1);
            chk("stall_addr", v.awv ? axi_awaddr : axi_araddr, v.addr);
        end
        chk("wr_ack", wr_ack, v.wack);
        chk("rd_ack", rd_ack, v.rack);
        @(negedge clk);
        axi_awready = 1'b0;
        axi_arready = 1'b0;
        wr_req = wr_req & ~drop[1:0];
        rd_req = rd_req & ~drop[3:2];
        for (int b = 0; b < v.beats; b++) begin
            wr_data    = {wpat(1, b), wpat(0, b)};
            axi_wready = v.awv;
            axi_rvalid = v.arv;
            axi_rdata  = rpat(b);
            axi_rlast  = v.arv && (b == v.rlast_beat);
            #1;
            chk("wr_next", wr_next, v.wack);
            chk("wr_done", wr_done, (b == v.beats - 1) ? v.wack : 2'b00);
            chk("rd_valid", rd_valid, v.rack);
            chk("rd_last", rd_last, (v.arv && b == v.rlast_beat) ? v.rack : 2'b00);
            if (v.awv) begin
                chk("wdata", axi_wdata, wpat(v.id, b));
                chk("wstrb", axi_wstrb, (v.id == 1) ? 32'h0F0F_0F0F : 32'hFFFF_FFFF);
            end else begin
                chk("rd_data", rd_data, rpat(b));
            end
            @(negedge clk);
        end
        axi_wready = 1'b0;
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        #1;
        chk("busy_end", busy, 1'b0);
        chk("len_err", len_err, v.err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t tbl[5];
        vec_t rr[5];
        vec_t v;
        logic bad;

        //        id addr         len stl rl  awv  arv  wack   rack   bts err
        rr[0] = '{0, 28'h0001000, 1, 0, -1, 1'b1, 1'b0, 2'b01, 2'b00, 2, 1'b0};
        rr[1] = '{1, 28'h0002000, 2, 2, -1, 1'b1, 1'b0, 2'b10, 2'b00, 3, 1'b0};
        rr[2] = '{2, 28'h0100000, 0, 0,  0, 1'b0, 1'b1, 2'b00, 2'b01, 1, 1'b0};
        rr[3] = '{3, 28'h0200000, 3, 1,  3, 1'b0, 1'b1, 2'b00, 2'b10, 4, 1'b0};
        rr[4] = rr[0];

        tbl[0] = '{1, 28'h0ABCDE0,  0, 0, -1, 1'b1, 1'b0, 2'b10, 2'b00,  1, 1'b0};
        tbl[1] = '{2, 28'h0FFFFF0, 15, 0, 15, 1'b0, 1'b1, 2'b00, 2'b01, 16, 1'b0};
        tbl[2] = '{0, 28'hFFFFFFF, 15, 3, -1, 1'b1, 1'b0, 2'b01, 2'b00, 16, 1'b0};
        tbl[3] = '{3, 28'h0000040,  1, 2,  1, 1'b0, 1'b1, 2'b00, 2'b10,  2, 1'b0};
        tbl[4] = '{0, 28'h0000000,  2, 1, -1, 1'b1, 1'b0, 2'b01, 2'b00,  3, 1'b0};

        rst = 1'b1; inited = 1'b1;
        wr_req = 2'b00; rd_req = 2'b00;
        wr_addr = '0; rd_addr = '0; wr_len = '0; rd_len = '0;
        wr_data = '0; wr_strb = {32'h0F0F_0F0F, 32'hFFFF_FFFF};
        axi_awready = 1'b0; axi_arready = 1'b0; axi_wready = 1'b0;
        axi_wusero_last = 1'b0; axi_rdata = '0; axi_rid = '0;
        axi_rlast = 1'b0; axi_rvalid = 1'b0;

        // Reset held with every requester asking: nothing may move.
        for (int i = 0; i < 4; i++) set_req(rr[i]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("reset_quiet", {axi_awvalid, axi_arvalid, wr_ack, rd_ack, wr_next,
                                wr_done, rd_valid, rd_last, busy}, 16'h0000);
        end
        chk("reset_len_err", len_err, 1'b0);
        rst = 1'b0;

        // All four held: W0 first, then W1, R0, R1, W0 again.
        for (int i = 0; i < 5; i++) begin
            serve(rr[i], (i == 4) ? 4'b1111 : 4'b0000);
        end

        // Single transactions across ports, lengths and address stalls.
        for (int i = 0; i < 5; i++) begin
            set_req(tbl[i]);
            serve(tbl[i], 4'b1111);
        end

        // Init gating: no grant while inited is low.
        inited = 1'b0;
        v = '{0, 28'h0001000, 7, 0, -1, 1'b1, 1'b0, 2'b01, 2'b00, 8, 1'b0};
        set_req(v);
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (axi_awvalid || busy) bad = 1'b1;
        end
        chk("init_blocks", bad, 1'b0);
        inited = 1'b1;
        serve(v, 4'b1111);

        // Reader 1 with a long arready stall.
        v = '{3, 28'h0300000, 3, 10, 3, 1'b0, 1'b1, 2'b00, 2'b10, 4, 1'b0};
        set_req(v);
        serve(v, 4'b1111);

        // Early rlast on beat 3 of an 8-beat read sets the sticky error.
        v = '{2, 28'h0400000, 7, 0, 2, 1'b0, 1'b1, 2'b00, 2'b01, 3, 1'b1};
        set_req(v);
        serve(v, 4'b1111);
        @(negedge clk); #1;
        chk("len_err_sticky", {len_err, busy}, 2'b10);

        // Reset during beat 4 of an 8-beat write.
        v = '{0, 28'h0003000, 7, 0, -1, 1'b1, 1'b0, 2'b01, 2'b00, 8, 1'b0};
        set_req(v);
        @(negedge clk);
        axi_awready = 1'b1;
        #1;
        chk("mid_rst_ack", wr_ack, 2'b01);
        @(negedge clk);
        axi_awready = 1'b0;
        wr_req = 2'b00;
        for (int b = 0; b < 4; b++) begin
            wr_data    = {wpat(1, b), wpat(0, b)};
            axi_wready = 1'b1;
            if (b == 3) rst = 1'b1;
            #1;
            chk("mid_rst_next", wr_next, 2'b01);
            @(negedge clk);
        end
        axi_wready = 1'b1;
        #1;
        chk("after_rst_quiet", {axi_awvalid, axi_arvalid, wr_ack, rd_ack, wr_next,
                                wr_done, rd_valid, rd_last, busy, len_err}, 17'h00000);
        axi_wready = 1'b0;
        rst = 1'b0;
        v = '{1, 28'h0005000, 2, 0, -1, 1'b1, 1'b0, 2'b10, 2'b00, 3, 1'b0};
        set_req(v);
        serve(v, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
